// File: rtl/kyber_pkg.sv
// Shared constants, state encoding and helpers for the Kyber encode path.
package kyber_pkg;

  localparam int COEFF_WORDS_PER_POLY = 128;

  // Legal ByteEncode widths
  localparam logic [3:0] L_1  = 4'd1;
  localparam logic [3:0] L_4  = 4'd4;
  localparam logic [3:0] L_5  = 4'd5;
  localparam logic [3:0] L_10 = 4'd10;
  localparam logic [3:0] L_11 = 4'd11;
  localparam logic [3:0] L_12 = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } enc_state_e;

  // 256 coeffs * l bits / 64 bits per word = 4*l output words per poly
  function automatic logic [7:0] obytes_per_poly(input logic [3:0] l);
    return {2'b00, l, 2'b00};
  endfunction

  function automatic logic l_legal(input logic [3:0] l);
    logic ok;
    case (l)
      L_1, L_4, L_5, L_10, L_11, L_12: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_coeff_fifo.sv
// 2-entry prefetch FIFO; head entry is always a register so dout is glitch-free.
module enc_coeff_fifo #(
  parameter int W = 24
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] ent0, ent1;
  logic [1:0]   cnt;
  logic         pop_ok, push_ok;

  assign pop_ok  = i_pop && (cnt != 2'd0);
  assign push_ok = i_push && ((cnt != 2'd2) || pop_ok);

  // Shift-style storage: ent0 is the head, ent1 the second word
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= i_din;
          else             ent1 <= i_din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) ent0 <= i_din;
          else begin
            ent0 <= ent1;
            ent1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout  = ent0;
  assign o_valid = (cnt != 2'd0);
  assign o_cnt   = cnt;

endmodule

// File: rtl/encode_ctrl.sv
// Sequences ByteEncode over 1..4 polys: RAM prefetch -> encode -> output RAM.
module encode_ctrl
  import kyber_pkg::*;
#(
  parameter int CADDR_W   = 9,
  parameter int OADDR_W   = 8,
  parameter int NPOLY_MAX = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [3:0]         i_l,
  input  logic [2:0]         i_npoly,
  input  logic [CADDR_W-1:0] i_cbase,
  input  logic [OADDR_W-1:0] i_obase,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [CADDR_W-1:0] o_cmem_addr,
  output logic               o_cmem_ren,
  input  logic [23:0]        i_cmem_rdata,
  output logic [23:0]        o_enc_coeffs,
  output logic               o_enc_coeffs_valid,
  output logic [3:0]         o_enc_l,
  input  logic               i_enc_coeffs_ready,
  input  logic [63:0]        i_enc_obytes,
  input  logic               i_enc_obytes_valid,
  input  logic               i_enc_done,
  output logic [OADDR_W-1:0] o_omem_addr,
  output logic               o_omem_wen,
  output logic [63:0]        o_omem_wdata
);

  enc_state_e         state, nstate;
  logic [3:0]         l_q;
  logic [2:0]         npoly_q, poly_q;
  logic [CADDR_W-1:0] cbase_q;
  logic [OADDR_W-1:0] obase_q;
  logic [7:0]         rd_idx, xfer_cnt, out_idx;
  logic               inflight, err_q;
  logic               wen_q;
  logic [OADDR_W-1:0] waddr_q;
  logic [63:0]        wdata_q;

  logic [23:0]        fifo_dout;
  logic               fifo_vld;
  logic [1:0]         fifo_cnt;

  logic               cmd_bad, rd_fire, xfer, last_xfer, obv_ok, poly_last;
  logic [7:0]         words_seen;
  logic [OADDR_W-1:0] poly_off;

  assign cmd_bad   = !l_legal(l_q) || (npoly_q == 3'd0) || (32'(npoly_q) > NPOLY_MAX);
  // At most two words outstanding (buffered or in the RAM pipe) so the FIFO never overflows
  assign rd_fire   = (state == ST_STREAM) && !rd_idx[7] &&
                     (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2);
  assign xfer      = fifo_vld && i_enc_coeffs_ready;
  assign last_xfer = xfer && (xfer_cnt == 8'd127);
  assign obv_ok    = i_enc_obytes_valid && ((state == ST_STREAM) || (state == ST_DRAIN));
  assign words_seen = out_idx + {7'd0, obv_ok};
  assign poly_last = (poly_q == (npoly_q - 3'd1));
  assign poly_off  = OADDR_W'(poly_q) * OADDR_W'(obytes_per_poly(l_q));

  enc_coeff_fifo #(.W(24)) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_push (inflight),
    .i_din  (i_cmem_rdata),
    .i_pop  (xfer),
    .o_dout (fifo_dout),
    .o_valid(fifo_vld),
    .o_cnt  (fifo_cnt)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (i_start) nstate = ST_CHECK;
      ST_CHECK:  nstate = cmd_bad ? ST_DONE : ST_STREAM;
      ST_STREAM: if (last_xfer) nstate = ST_DRAIN;
      ST_DRAIN:  if (i_enc_done) nstate = poly_last ? ST_DONE : ST_STREAM;
      ST_DONE:   nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  // FSM-decoded status outputs
  always_comb begin
    o_busy = (state == ST_CHECK) || (state == ST_STREAM) || (state == ST_DRAIN);
    o_done = (state == ST_DONE);
  end

  // Command latch, per-poly counters and sticky error
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      l_q      <= '0;
      npoly_q  <= '0;
      cbase_q  <= '0;
      obase_q  <= '0;
      poly_q   <= '0;
      rd_idx   <= '0;
      xfer_cnt <= '0;
      out_idx  <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && i_start) begin
        l_q     <= i_l;
        npoly_q <= i_npoly;
        cbase_q <= i_cbase;
        obase_q <= i_obase;
        err_q   <= 1'b0;
      end
      if (state == ST_CHECK) begin
        poly_q   <= '0;
        rd_idx   <= '0;
        xfer_cnt <= '0;
        out_idx  <= '0;
        if (cmd_bad) err_q <= 1'b1;
      end
      if (rd_fire) rd_idx   <= rd_idx + 8'd1;
      if (xfer)    xfer_cnt <= xfer_cnt + 8'd1;
      if (obv_ok)  out_idx  <= out_idx + 8'd1;
      // Poly boundary: count check, then rewind counters for the next poly
      if ((state == ST_DRAIN) && i_enc_done) begin
        if (words_seen != obytes_per_poly(l_q)) err_q <= 1'b1;
        if (!poly_last) begin
          poly_q   <= poly_q + 3'd1;
          rd_idx   <= '0;
          xfer_cnt <= '0;
          out_idx  <= '0;
        end
      end
    end
  end

  // Tracks the one-cycle RAM read latency
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) inflight <= 1'b0;
    else         inflight <= rd_fire;
  end

  // Registered output RAM write port
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= obv_ok;
      if (obv_ok) begin
        waddr_q <= obase_q + poly_off + OADDR_W'(out_idx);
        wdata_q <= i_enc_obytes;
      end
    end
  end

  assign o_cmem_ren         = rd_fire;
  assign o_cmem_addr        = cbase_q + CADDR_W'(poly_q) * CADDR_W'(COEFF_WORDS_PER_POLY) +
                              CADDR_W'(rd_idx);
  assign o_enc_coeffs       = fifo_dout;
  assign o_enc_coeffs_valid = fifo_vld;
  assign o_enc_l            = l_q;
  assign o_err              = err_q;
  assign o_omem_wen         = wen_q;
  assign o_omem_addr        = waddr_q;
  assign o_omem_wdata       = wdata_q;

endmodule

// File: tb/tb_encode_ctrl.sv
// Bench for encode_ctrl: RAM + encode models, queue scoreboard on reads, coeffs and writes.
module tb_encode_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b1;
  logic        i_start = 1'b0;
  logic [3:0]  i_l = '0;
  logic [2:0]  i_npoly = '0;
  logic [8:0]  i_cbase = '0;
  logic [7:0]  i_obase = '0;
  logic        o_busy, o_done, o_err;
  logic [8:0]  o_cmem_addr;
  logic        o_cmem_ren;
  logic [23:0] i_cmem_rdata = '0;
  logic [23:0] o_enc_coeffs;
  logic        o_enc_coeffs_valid;
  logic [3:0]  o_enc_l;
  logic        i_enc_coeffs_ready = 1'b1;
  logic [63:0] i_enc_obytes = '0;
  logic        i_enc_obytes_valid = 1'b0;
  logic        i_enc_done = 1'b0;
  logic [7:0]  o_omem_addr;
  logic        o_omem_wen;
  logic [63:0] o_omem_wdata;

  encode_ctrl dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_l(i_l), .i_npoly(i_npoly),
    .i_cbase(i_cbase), .i_obase(i_obase), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cmem_addr(o_cmem_addr), .o_cmem_ren(o_cmem_ren), .i_cmem_rdata(i_cmem_rdata),
    .o_enc_coeffs(o_enc_coeffs), .o_enc_coeffs_valid(o_enc_coeffs_valid), .o_enc_l(o_enc_l),
    .i_enc_coeffs_ready(i_enc_coeffs_ready), .i_enc_obytes(i_enc_obytes),
    .i_enc_obytes_valid(i_enc_obytes_valid), .i_enc_done(i_enc_done),
    .o_omem_addr(o_omem_addr), .o_omem_wen(o_omem_wen), .o_omem_wdata(o_omem_wdata)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [23:0] ram [0:511];
  logic [23:0] exp_coef[$];
  logic [8:0]  exp_rd[$];
  logic [71:0] exp_wr[$];

  // model / command state
  int m_l = 0, m_obase = 0, m_poly = 0, m_xfer = 0, m_widx = 0, m_nw = 0;
  bit m_rnd = 0, m_short = 0, m_emit = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  logic done_err = 1'b0;
  bit prev_stall = 0;
  logic [23:0] prev_data = '0;

  always @(posedge i_clk) cyc++;

  // Coefficient RAM: one-cycle registered read
  always @(posedge i_clk) if (o_cmem_ren) i_cmem_rdata <= ram[o_cmem_addr];

  // Monitors + encode model, all evaluated away from the active edge
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      chk("rst_out", {13'd0, o_busy, o_done, o_err, o_cmem_ren, o_enc_coeffs_valid, o_omem_wen,
                      o_enc_l, o_cmem_addr, o_omem_addr, o_enc_coeffs}, 64'd0);
      chk("rst_wdata", o_omem_wdata, 64'd0);
      m_poly = 0; m_xfer = 0; m_emit = 0; m_widx = 0; prev_stall = 0;
      i_enc_obytes_valid = 1'b0; i_enc_done = 1'b0;
      exp_coef.delete(); exp_rd.delete(); exp_wr.delete();
    end else begin
      if (o_omem_wen) begin
        logic [71:0] e;
        wr_cnt++;
        if (exp_wr.size() == 0) chk("wr_extra", 64'd1, 64'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(o_omem_addr), 64'(e[71:64]));
          chk("wr_data", o_omem_wdata, e[63:0]);
        end
      end
      if (o_cmem_ren) begin
        rd_cnt++;
        if (exp_rd.size() == 0) chk("rd_extra", 64'd1, 64'd0);
        else chk("rd_addr", 64'(o_cmem_addr), 64'(exp_rd.pop_front()));
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = o_err;
      end
      if (prev_stall) begin
        chk("stall_vld", 64'(o_enc_coeffs_valid), 64'd1);
        chk("stall_dat", 64'(o_enc_coeffs), 64'(prev_data));
      end
      // encode output side: words, then a done pulse
      i_enc_obytes_valid = 1'b0;
      i_enc_done = 1'b0;
      if (m_emit) begin
        if (m_widx < m_nw) begin
          logic [63:0] d;
          d = {$urandom, $urandom};
          i_enc_obytes = d;
          i_enc_obytes_valid = 1'b1;
          exp_wr.push_back({8'(m_obase + m_poly * 4 * m_l + m_widx), d});
          m_widx++;
        end else begin
          i_enc_done = 1'b1;
          m_emit = 0;
          m_poly++;
        end
      end
      // encode input side
      i_enc_coeffs_ready = m_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_enc_coeffs_valid && i_enc_coeffs_ready) begin
        if (exp_coef.size() == 0) chk("coef_extra", 64'd1, 64'd0);
        else chk("coef", 64'(o_enc_coeffs), 64'(exp_coef.pop_front()));
        m_xfer++;
        if (m_xfer == 128) begin
          m_xfer = 0;
          m_emit = 1;
          m_widx = 0;
          m_nw = (m_short && m_poly == 0) ? 4 * m_l - 1 : 4 * m_l;
        end
      end
      prev_stall = o_enc_coeffs_valid && !i_enc_coeffs_ready;
      prev_data  = o_enc_coeffs;
    end
  end

  function automatic bit legal_cmd(input int l, input int np);
    return (l == 1 || l == 4 || l == 5 || l == 10 || l == 11 || l == 12) && np >= 1 && np <= 4;
  endfunction

  task automatic launch_cmd(input int l, input int np, input int cb, input int ob,
                            input bit rnd, input bit shrt);
    m_l = l; m_obase = ob; m_rnd = rnd; m_short = shrt;
    m_poly = 0; m_xfer = 0; m_emit = 0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    if (legal_cmd(l, np))
      for (int p = 0; p < np; p++)
        for (int k = 0; k < 128; k++) begin
          int a;
          a = (cb + p * 128 + k) % 512;
          exp_rd.push_back(9'(a));
          exp_coef.push_back(ram[a]);
        end
    @(posedge i_clk); #1;
    i_l = 4'(l); i_npoly = 3'(np); i_cbase = 9'(cb); i_obase = 8'(ob);
    i_start = 1'b1;
    start_cyc = cyc;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_cmd(input int l, input int np, input int cb, input int ob,
                         input bit rnd, input bit shrt, input logic exp_err);
    int nwr;
    bit ok;
    ok = legal_cmd(l, np);
    launch_cmd(l, np, cb, ob, rnd, shrt);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(posedge i_clk);
    if (done_cnt == 0) chk("timeout", 64'd0, 64'd1);
    repeat (4) @(posedge i_clk);
    #1;
    nwr = ok ? np * 4 * l - (shrt ? 1 : 0) : 0;
    chk("done_cnt", 64'(done_cnt), 64'd1);
    chk("done_err", 64'(done_err), 64'(exp_err));
    chk("err_held", 64'(o_err), 64'(exp_err));
    chk("busy_idle", 64'(o_busy), 64'd0);
    chk("rd_cnt", 64'(rd_cnt), ok ? 64'(np * 128) : 64'd0);
    chk("wr_cnt", 64'(wr_cnt), 64'(nwr));
    chk("q_left", 64'(exp_coef.size() + exp_rd.size() + exp_wr.size()), 64'd0);
    if (!ok) chk("chk_lat", 64'(done_cyc - start_cyc), 64'd2);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 24'($urandom);
    #1 i_rstn = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;

    run_cmd(4, 1, 0, 0, 0, 0, 1'b0);
    run_cmd(12, 3, 0, 10, 0, 0, 1'b0);
    run_cmd(10, 2, 100, 200, 1, 0, 1'b0);   // output address wraps past 255
    run_cmd(7, 1, 0, 0, 0, 0, 1'b1);        // illegal l
    run_cmd(4, 0, 0, 0, 0, 0, 1'b1);        // illegal npoly
    run_cmd(10, 2, 384, 0, 1, 1, 1'b1);     // 39 words on poly 0; coeff address wraps

    // abort mid-stream with start held through reset
    launch_cmd(10, 2, 5, 5, 1, 0);
    repeat (100) @(posedge i_clk);
    #1 i_start = 1'b1;
    #1 i_rstn = 1'b0;
    #1;
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_out", {o_cmem_ren, o_omem_wen, o_enc_coeffs_valid, o_err, o_done}, 64'd0);
    repeat (3) @(posedge i_clk);
    #1 i_start = 1'b0;
    #1 i_rstn = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 chk("post_rst_idle", 64'(o_busy), 64'd0);
    run_cmd(1, 1, 0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encode_ctrl.md
Name: encode_ctrl

Overview:
- Sequences the ByteEncode datapath (`encode`) over a vector of 1..4 polynomials.
- Fetches packed coefficient pairs from coefficient RAM and streams them to `encode` under its ready/valid handshake.
- Collects the 64-bit output words and writes them to output RAM at computed addresses.
- Reports completion and error status to the top-level Kyber sequencer.

Parameters:
- CADDR_W, 9, coefficient RAM word-address width (4 polys x 128 words).
- OADDR_W, 8, output RAM word-address width (max 4 x 48 words).
- NPOLY_MAX, 4, maximum polynomials per command.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  command strobe; sampled only in IDLE
- i_l  in  4  encode width; legal values 1, 4, 5, 10, 11, 12
- i_npoly  in  3  polynomial count, legal range 1..4
- i_cbase  in  CADDR_W  coefficient RAM base word address
- i_obase  in  OADDR_W  output RAM base word address
- o_busy  out  1  high from the accepted start until DONE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  status for the last command; valid with o_done, held until the next accepted start
- o_cmem_addr  out  CADDR_W  coefficient RAM read address
- o_cmem_ren  out  1  coefficient RAM read enable; read data arrives 1 cycle later
- i_cmem_rdata  in  24  {coeff[2j+1][11:0], coeff[2j][11:0]}
- o_enc_coeffs  out  24  to encode i_coeffs
- o_enc_coeffs_valid  out  1  to encode i_coeffs_valid
- o_enc_l  out  4  to encode i_l; held stable for the whole command
- i_enc_coeffs_ready  in  1  from encode o_coeffs_ready
- i_enc_obytes  in  64  from encode o_obytes
- i_enc_obytes_valid  in  1  from encode o_obytes_valid
- i_enc_done  in  1  from encode o_done
- o_omem_addr  out  OADDR_W  output RAM write address
- o_omem_wen  out  1  output RAM write enable
- o_omem_wdata  out  64  output RAM write data

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rstn.
- Reset values: all outputs 0, FSM in IDLE, all counters 0, prefetch FIFO empty.
- Reset asserted mid-operation aborts immediately. No RAM write may occur while i_rstn is low.

FSM states and transitions:
- IDLE: on i_start, latch l, npoly, cbase, obase; clear o_err; set o_busy; go to CHECK.
- CHECK (1 cycle): if l is not legal or npoly is not in 1..4, set o_err and go to DONE. Otherwise poly=0 and go to STREAM.
- STREAM: issue 128 reads at cbase + poly*128 + rd_idx. A read is issued only when FIFO occupancy plus reads in flight is less than 2. FIFO head drives o_enc_coeffs/o_enc_coeffs_valid. A word transfers when valid && ready. After the 128th transfer, go to DRAIN.
- DRAIN: wait for i_enc_done. Then, if poly == npoly-1, go to DONE; otherwise poly++, reset per-poly counters, go to STREAM.
- DONE (1 cycle): o_done=1, o_busy=0, go to IDLE.
- i_start is ignored in every state except IDLE.

Handshake and ordering:
- o_enc_coeffs_valid never drops without a transfer.
- Data is stable while valid && !ready.
- Order is strict: the FIFO never drops or duplicates a word.

Output path (active in STREAM and DRAIN):
- Each i_enc_obytes_valid produces one registered write: o_omem_wen=1, o_omem_wdata=i_enc_obytes, o_omem_addr=obase + poly*4*l + out_idx.
- out_idx increments after each write. Write latency is 1 cycle.
- Expected words per poly = 4*l (4, 16, 20, 40, 44, 48).
- At i_enc_done, if out_idx != 4*l, o_err is set (sticky for the command); sequencing continues.

Arithmetic: address sums wrap modulo 2^CADDR_W and 2^OADDR_W. poly*4*l is computed at OADDR_W width.

Decomposition:
- kyber_pkg holds: legal-L constants, COEFF_WORDS_PER_POLY=128, OBYTES_PER_POLY(l)=4*l function, encode_ctrl state encodings.
- One sub-module, enc_coeff_fifo: 2-entry, 24-bit, registered-output FIFO with push/pop/occupancy, instantiated for the RAM-latency prefetch.

Test Plan:
- l=4, npoly=1, cbase=0, obase=0, ready tied 1: exactly 128 transfers in address order 0..127; 16 writes at addresses 0..15; one o_done pulse with o_err=0.
- l=12, npoly=3, cbase=0, obase=10: writes at 10..153 (48 per poly); coefficient reads 0..383; o_done pulses once.
- l=10, npoly=2, ready toggled with a random 50% duty: the word sequence seen at encode equals RAM contents exactly; no drops or duplicates; data stable while stalled.
- l=7 and, separately, npoly=0: no RAM read or write; o_done 2 cycles after start with o_err=1.
- Encode model emitting 39 words for l=10: o_err=1 at o_done; the second poly is still processed.
- Reset pulsed mid-STREAM with i_start held high during reset: all outputs 0; after release, a new start runs a clean l=1 command producing 4 writes.
